// File: rtl/lbm_node_scanner.sv
// lbm_node_scanner: raster-order lattice node sequencer for the LBM pipeline.
// Walks an NX-by-NY grid (x = row, y = column), emitting one node per accepted
// valid/ready beat with boundary classification flags aligned to x/y.
// Optional feature macro: LBM_MULTI_SWEEP_EN (repeat sweeps for num_sweeps
// timesteps, exposing the current sweep index).
module lbm_node_scanner #(
  parameter int NX         = 16,
  parameter int NY         = 16,
  parameter int X_WIDTH    = $clog2(NX),
  parameter int Y_WIDTH    = $clog2(NY),
  parameter int ADDR_WIDTH = $clog2(NX*NY)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  out_ready,
`ifdef LBM_MULTI_SWEEP_EN
  input  logic [15:0]           num_sweeps,
  output logic [15:0]           sweep,
`endif
  output logic                  out_valid,
  output logic [X_WIDTH-1:0]    x,
  output logic [Y_WIDTH-1:0]    y,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  lid,
  output logic                  bottom_wall,
  output logic                  left_wall,
  output logic                  right_wall,
  output logic                  corner,
  output logic                  interior,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(NX - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(NY - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [X_WIDTH-1:0]    r_x;
  logic [Y_WIDTH-1:0]    r_y;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_done;

  logic w_scan;
  logic w_accept;
  logic w_last_node;
  logic w_final;

`ifdef LBM_MULTI_SWEEP_EN
  logic [15:0] r_sweep;
  logic [15:0] r_sweep_last;
`endif

  assign w_scan      = (r_state == SCAN);
  assign w_accept    = w_scan && out_ready;
  assign w_last_node = (r_x == X_LAST) && (r_y == Y_LAST);
`ifdef LBM_MULTI_SWEEP_EN
  assign w_final     = w_last_node && (r_sweep == r_sweep_last);
`else
  assign w_final     = w_last_node;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; abort takes precedence over a simultaneous accept.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (start) w_next_state = SCAN;
      SCAN: begin
        if (abort)                    w_next_state = IDLE;
        else if (w_accept && w_final) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Coordinate/address counters, sweep tracking and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
      r_done <= 1'b0;
`ifdef LBM_MULTI_SWEEP_EN
      r_sweep      <= '0;
      r_sweep_last <= '0;
`endif
    end else begin
      r_done <= w_accept && !abort && w_final;
      if (!w_scan || abort) begin
        r_x    <= '0;
        r_y    <= '0;
        r_addr <= '0;
`ifdef LBM_MULTI_SWEEP_EN
        r_sweep <= '0;
        if (!w_scan && start)
          r_sweep_last <= (num_sweeps == 16'd0) ? 16'd0 : num_sweeps - 16'd1;
`endif
      end else if (w_accept) begin
        if (w_last_node) begin
          // End of a sweep: rewind with no bubble; a non-final sweep keeps SCAN.
          r_x    <= '0;
          r_y    <= '0;
          r_addr <= '0;
`ifdef LBM_MULTI_SWEEP_EN
          r_sweep <= w_final ? 16'd0 : r_sweep + 16'd1;
`endif
        end else if (r_y == Y_LAST) begin
          r_y    <= '0;
          r_x    <= r_x + X_WIDTH'(1);
          r_addr <= r_addr + ADDR_WIDTH'(1);
        end else begin
          r_y    <= r_y + Y_WIDTH'(1);
          r_addr <= r_addr + ADDR_WIDTH'(1);
        end
      end
    end
  end

  // Outputs: everything forced to zero outside SCAN; flags decoded from registered x/y.
  always_comb begin
    out_valid   = w_scan;
    busy        = w_scan;
    done        = r_done;
    x           = w_scan ? r_x    : '0;
    y           = w_scan ? r_y    : '0;
    addr        = w_scan ? r_addr : '0;
    lid         = w_scan && (r_x == X_LAST);
    bottom_wall = w_scan && (r_x == '0);
    left_wall   = w_scan && (r_y == '0);
    right_wall  = w_scan && (r_y == Y_LAST);
    corner      = (lid && bottom_wall) || (lid && left_wall) || (lid && right_wall) ||
                  (bottom_wall && left_wall) || (bottom_wall && right_wall) ||
                  (left_wall && right_wall);
    interior    = w_scan && !(lid || bottom_wall || left_wall || right_wall);
`ifdef LBM_MULTI_SWEEP_EN
    sweep       = w_scan ? r_sweep : '0;
`endif
  end

endmodule

// File: tb/tb_lbm_node_scanner.sv
// Testbench for lbm_node_scanner: 16x16 and 5x3 instances, directed vectors.
// Multi-sweep checks are compiled only with LBM_MULTI_SWEEP_EN.
module tb_lbm_node_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 16x16 instance
  logic       reset, start, abort, out_ready;
  logic       out_valid, lid, bottom_wall, left_wall, right_wall, corner, interior, busy, done;
  logic [3:0] x, y;
  logic [7:0] addr;
`ifdef LBM_MULTI_SWEEP_EN
  logic [15:0] num_sweeps, sweep, num_sweeps_s, sweep_s;
`endif

  // 5x3 instance
  logic       start_s, ready_s, abort_s;
  logic       valid_s, lid_s, bot_s, left_s, right_s, corner_s, int_s, busy_s, done_s;
  logic [2:0] x_s;
  logic [1:0] y_s;
  logic [3:0] addr_s;

  lbm_node_scanner #(.NX(16), .NY(16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .out_ready(out_ready),
`ifdef LBM_MULTI_SWEEP_EN
    .num_sweeps(num_sweeps), .sweep(sweep),
`endif
    .out_valid(out_valid), .x(x), .y(y), .addr(addr),
    .lid(lid), .bottom_wall(bottom_wall), .left_wall(left_wall), .right_wall(right_wall),
    .corner(corner), .interior(interior), .busy(busy), .done(done)
  );

  lbm_node_scanner #(.NX(5), .NY(3)) u_small (
    .clk(clk), .reset(reset), .start(start_s), .abort(abort_s), .out_ready(ready_s),
`ifdef LBM_MULTI_SWEEP_EN
    .num_sweeps(num_sweeps_s), .sweep(sweep_s),
`endif
    .out_valid(valid_s), .x(x_s), .y(y_s), .addr(addr_s),
    .lid(lid_s), .bottom_wall(bot_s), .left_wall(left_s), .right_wall(right_s),
    .corner(corner_s), .interior(int_s), .busy(busy_s), .done(done_s)
  );

  // flags packed as {lid, bottom, left, right, corner, interior}
  typedef struct {
    int       nx;
    int       ny;
    logic [5:0] flags;
  } flag_vec_t;

  typedef struct {
    logic [2:0] ex;
    logic [1:0] ey;
    logic [3:0] eaddr;
    logic [5:0] flags;
  } small_vec_t;

  flag_vec_t  big_tab[8];
  small_vec_t small_tab[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] big_flags();
    return {lid, bottom_wall, left_wall, right_wall, corner, interior};
  endfunction

  function automatic logic [5:0] small_flags();
    return {lid_s, bot_s, left_s, right_s, corner_s, int_s};
  endfunction

  initial begin
    big_tab[0] = '{13,  3, 6'b000001};
    big_tab[1] = '{15,  2, 6'b100000};
    big_tab[2] = '{ 0,  5, 6'b010000};
    big_tab[3] = '{15,  0, 6'b101010};
    big_tab[4] = '{ 9, 15, 6'b000100};
    big_tab[5] = '{ 0,  0, 6'b011010};
    big_tab[6] = '{15, 15, 6'b100110};
    big_tab[7] = '{ 0, 15, 6'b010110};

    small_tab[0]  = '{3'd0, 2'd0, 4'd0,  6'b011010};
    small_tab[1]  = '{3'd0, 2'd1, 4'd1,  6'b010000};
    small_tab[2]  = '{3'd0, 2'd2, 4'd2,  6'b010110};
    small_tab[3]  = '{3'd1, 2'd0, 4'd3,  6'b001000};
    small_tab[4]  = '{3'd1, 2'd1, 4'd4,  6'b000001};
    small_tab[5]  = '{3'd1, 2'd2, 4'd5,  6'b000100};
    small_tab[6]  = '{3'd2, 2'd0, 4'd6,  6'b001000};
    small_tab[7]  = '{3'd2, 2'd1, 4'd7,  6'b000001};
    small_tab[8]  = '{3'd2, 2'd2, 4'd8,  6'b000100};
    small_tab[9]  = '{3'd3, 2'd0, 4'd9,  6'b001000};
    small_tab[10] = '{3'd3, 2'd1, 4'd10, 6'b000001};
    small_tab[11] = '{3'd3, 2'd2, 4'd11, 6'b000100};
    small_tab[12] = '{3'd4, 2'd0, 4'd12, 6'b101010};
    small_tab[13] = '{3'd4, 2'd1, 4'd13, 6'b100000};
    small_tab[14] = '{3'd4, 2'd2, 4'd14, 6'b100110};

    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start_s = 1'b0; ready_s = 1'b0; abort_s = 1'b0;
`ifdef LBM_MULTI_SWEEP_EN
    num_sweeps = 16'd1; num_sweeps_s = 16'd1;
`endif
    tick(); tick();

    // Reset state
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_flags", 32'(big_flags()), 0);
    check("rst_small_flags", 32'(small_flags()), 0);
    reset = 1'b0;
    tick();

    // Full 16x16 sweep with out_ready held high
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 256; k++) begin
      check("sweep_valid", 32'(out_valid), 1);
      check("sweep_busy", 32'(busy), 1);
      check("sweep_done", 32'(done), 0);
      check("sweep_addr", 32'(addr), 32'(k));
      check("sweep_x", 32'(x), 32'(k / 16));
      check("sweep_y", 32'(y), 32'(k % 16));
      for (int e = 0; e < 8; e++)
        if (big_tab[e].nx * 16 + big_tab[e].ny == k)
          check("node_flags", 32'(big_flags()), 32'(big_tab[e].flags));
      tick();
    end
    check("end_done", 32'(done), 1);
    check("end_busy", 32'(busy), 0);
    check("end_valid", 32'(out_valid), 0);
    check("end_flags", 32'(big_flags()), 0);
    tick();
    check("done_pulse_width", 32'(done), 0);

    // Random back-pressure: model count advances only on accept
    begin
      int cnt = 0;
      bit seen_done = 0;
      start = 1'b1; out_ready = 1'b0;
      tick();
      start = 1'b0;
      for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
        if (done) begin
          seen_done = 1;
        end else begin
          check("stall_valid", 32'(out_valid), 1);
          check("stall_addr", 32'(addr), 32'(cnt));
          check("stall_x", 32'(x), 32'(cnt / 16));
          check("stall_y", 32'(y), 32'(cnt % 16));
          out_ready = 1'($urandom_range(0, 1));
          start = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) cnt++;
          tick();
        end
      end
      start = 1'b0;
      check("stall_done_seen", 32'(seen_done), 1);
      check("stall_total", 32'(cnt), 256);
      check("stall_end_valid", 32'(out_valid), 0);
      tick();
    end

    // Abort at (4,7) while stalled
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (71) tick();
    check("abort_pre_x", 32'(x), 4);
    check("abort_pre_y", 32'(y), 7);
    out_ready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", 32'(out_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_addr", 32'(addr), 0);
    tick();
    check("abort_done_later", 32'(done), 0);

    // Restart from (0,0), then abort on the last node with a simultaneous accept
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    check("restart_valid", 32'(out_valid), 1);
    check("restart_addr", 32'(addr), 0);
    check("restart_xy", 32'({x, y}), 0);
    repeat (255) tick();
    check("last_addr", 32'(addr), 255);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_last_valid", 32'(out_valid), 0);
    check("abort_last_done", 32'(done), 0);
    tick();
    check("abort_last_done2", 32'(done), 0);

    // Reset mid-scan
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("mid_addr", 32'(addr), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_addr", 32'(addr), 0);
    tick();
    check("midrst_done2", 32'(done), 0);

    // 5x3 grid, table driven
    start_s = 1'b1; ready_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int k = 0; k < 15; k++) begin
      check("small_valid", 32'(valid_s), 1);
      check("small_x", 32'(x_s), 32'(small_tab[k].ex));
      check("small_y", 32'(y_s), 32'(small_tab[k].ey));
      check("small_addr", 32'(addr_s), 32'(small_tab[k].eaddr));
      check("small_flags", 32'(small_flags()), 32'(small_tab[k].flags));
      check("small_done", 32'(done_s), 0);
      tick();
    end
    check("small_end_done", 32'(done_s), 1);
    check("small_end_valid", 32'(valid_s), 0);
    tick();
    check("small_done_pulse", 32'(done_s), 0);

`ifdef LBM_MULTI_SWEEP_EN
    // Three back-to-back sweeps with one done pulse
    num_sweeps = 16'd3; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 768; k++) begin
      check("ms_valid", 32'(out_valid), 1);
      check("ms_addr", 32'(addr), 32'(k % 256));
      check("ms_sweep", 32'(sweep), 32'(k / 256));
      check("ms_done", 32'(done), 0);
      tick();
    end
    check("ms_end_done", 32'(done), 1);
    check("ms_end_valid", 32'(out_valid), 0);
    tick();

    // num_sweeps=0 behaves as one sweep
    num_sweeps = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 256; k++) begin
      check("ms0_addr", 32'(addr), 32'(k));
      check("ms0_sweep", 32'(sweep), 0);
      tick();
    end
    check("ms0_done", 32'(done), 1);
    check("ms0_valid", 32'(out_valid), 0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lbm_node_scanner.md
# lbm_node_scanner

Parametrised lattice-node sequencer for the LBM pipeline: walks an NX-by-NY grid in raster order, emitting one node coordinate per accepted beat together with registered boundary classification (lid, bottom, left, right, corner, interior). It generalises the fixed 16x16 wall detection to arbitrary rectangular grids, adds a valid/ready output handshake with back-pressure and abort, and optionally repeats sweeps for multiple timesteps. It sits between the top-level control FSM and the collision/streaming datapath, supplying node addresses and boundary-condition selects.

## Interface
- NX, 16, grid extent along x (x=0 bottom wall, x=NX-1 lid); NX >= 2
- NY, 16, grid extent along y (y=0 left wall, y=NY-1 right wall); NY >= 2
- X_WIDTH, $clog2(NX), x coordinate width
- Y_WIDTH, $clog2(NY), y coordinate width
- ADDR_WIDTH, $clog2(NX*NY), linear node address width

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a scan; sampled only in IDLE
- abort  in  1  terminate scan; sampled only in SCAN
- out_ready  in  1  downstream accepts current beat
- out_valid  out  1  x/y/addr/flags valid
- x  out  X_WIDTH  node row
- y  out  Y_WIDTH  node column
- addr  out  ADDR_WIDTH  x*NY + y
- lid, bottom_wall, left_wall, right_wall  out  1 each  boundary flags
- corner  out  1  two or more wall flags set
- interior  out  1  no wall flag set
- busy  out  1  state is SCAN
- done  out  1  one-cycle pulse after final beat accepted

## Operation
- States: IDLE, SCAN. Reset -> IDLE; all outputs 0 (interior 0 while out_valid 0).
- IDLE: start=1 -> SCAN, x=0, y=0, addr=0. start ignored in SCAN.
- SCAN: out_valid=1. Beat accepted when out_valid && out_ready.
- On accept: y increments; y==NY-1 -> y=0, x increments; addr increments by 1. No wrap beyond the last node.
- Last node (x=NX-1, y=NY-1) accepted -> IDLE, done=1 for one cycle.
- Stall: out_valid && !out_ready -> x, y, addr, all flags held stable.
- Flags combinational only on registered x/y, or registered alongside; in either case aligned with x/y every cycle: lid = (x==NX-1), bottom_wall = (x==0), left_wall = (y==0), right_wall = (y==NY-1). Multiple flags may be set simultaneously (corners); no priority masking.
- abort=1 in SCAN -> IDLE next cycle, out_valid 0, done NOT asserted; abort wins over a simultaneous accept.
- Reset mid-scan: same as abort; done 0.
- Outside SCAN, x/y/addr/flags driven 0.

## Timing
- start sampled at edge t -> out_valid=1 with node (0,0) from cycle t+1.
- With out_ready held 1: one node per cycle; NX*NY beats in cycles t+1 .. t+NX*NY.
- done high in cycle t+NX*NY+1; busy low same cycle; a new start is accepted in that cycle.
- abort at edge t -> out_valid 0 in cycle t+1.

## Configuration
- LBM_MULTI_SWEEP_EN defined: adds input num_sweeps [15:0] (sampled with start) and output sweep [15:0] (current sweep index, 0-based). After the last node of a non-final sweep, x/y/addr return to 0 and sweep increments with no bubble cycle; done pulses only after the last node of sweep num_sweeps-1. num_sweeps=0 is treated as 1. sweep resets to 0.
- Not defined: ports absent, exactly one sweep per start.

## Test plan
- Reset, then start with NX=NY=16, out_ready=1 -> 256 beats, addr 0..255 consecutive, done pulse exactly 257 cycles after start, busy low the same cycle.
- Flag check during that sweep: (13,3) interior=1; (15,2) lid=1 only; (0,5) bottom_wall=1 only; (15,0) lid+left_wall, corner=1; (9,15) right_wall=1 only.
- Random out_ready deassertion (~50%) -> no node skipped or duplicated, outputs stable while stalled, total accepted = 256.
- abort asserted at node (4,7) while out_ready=0 -> out_valid 0 next cycle, no done; restart begins at (0,0).
- NX=5, NY=3 -> 15 beats, lid at x=4, right_wall at y=2, addr = x*3+y.
- With LBM_MULTI_SWEEP_EN, num_sweeps=3 -> 768 back-to-back beats, sweep 0/1/2, single done pulse; num_sweeps=0 -> one sweep.
